// File: rtl/hilo_muldiv_pkg.sv
// hilo_muldiv_pkg: op encodings, HI/LO write-enable bit positions and FSM states
// shared by the multiply/divide unit and the HI/LO register.
package hilo_muldiv_pkg;
    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5
    } op_e;

    localparam int HILO_HI_BIT = 1;
    localparam int HILO_LO_BIT = 0;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_e;
endpackage

// File: rtl/hilo_muldiv_div_iter.sv
// hilo_muldiv_div_iter: restoring divider core on unsigned magnitudes,
// one quotient bit per cycle while en is high.
module hilo_muldiv_div_iter #(
    parameter int DIV_ITERS = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        en,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic [31:0] quot,
    output logic [31:0] rem,
    output logic        done
);
    logic [31:0] quot_q, quot_d, rem_q, rem_d, dvsr_q, dvsr_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [32:0] trial;

    assign quot = quot_q;
    assign rem  = rem_q;
    assign done = cnt_q == 5'(DIV_ITERS - 1);

    // The dividend shifts out of quot_q's MSB as quotient bits shift in at the LSB.
    always_comb begin
        trial  = {rem_q, quot_q[31]} - {1'b0, dvsr_q};
        rem_d  = start ? '0 : en ? (trial[32] ? {rem_q[30:0], quot_q[31]} : trial[31:0]) : rem_q;
        quot_d = start ? dividend : en ? {quot_q[30:0], ~trial[32]} : quot_q;
        dvsr_d = start ? divisor : dvsr_q;
        cnt_d  = start ? '0 : en ? cnt_q + 5'd1 : cnt_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            quot_q <= '0;
            rem_q  <= '0;
            dvsr_q <= '0;
            cnt_q  <= '0;
        end else begin
            quot_q <= quot_d;
            rem_q  <= rem_d;
            dvsr_q <= dvsr_d;
            cnt_q  <= cnt_d;
        end
    end
endmodule

// File: rtl/hilo_muldiv.sv
// hilo_muldiv: MULT/MULTU/DIV/DIVU/MTHI/MTLO execution unit delivering each result
// as a single-cycle HI/LO write pulse.
module hilo_muldiv
    import hilo_muldiv_pkg::*;
#(
    parameter int DIV_ITERS = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        op_valid,
    input  logic [2:0]  op_code,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        flush,
    output logic        op_ready,
    output logic [1:0]  w_hilo_ena,
    output logic [31:0] w_hi_data,
    output logic [31:0] w_lo_data
);
    state_e             state_q, state_d;
    logic [2:0]         op_q, op_d;
    logic [31:0]        a_q, a_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d;
    logic [1:0]         ena_q, ena_d;
    logic signed [32:0] mul_a, mul_b;
    logic signed [63:0] prod;
    logic               in_signed, div_start, div_done, q_neg, r_neg;
    logic [31:0]        mag_a, mag_b, quot, rem;

    assign op_ready   = state_q == S_IDLE;
    assign w_hilo_ena = ena_q;
    assign w_hi_data  = hi_q;
    assign w_lo_data  = lo_q;

    assign mul_a = {op_q == OP_MULT && a_q[31], a_q};
    assign mul_b = {op_q == OP_MULT && b_q[31], b_q};
    assign prod  = 64'(mul_a) * 64'(mul_b);

    // Magnitudes are taken straight from the inputs so the divider loads on the accept edge.
    assign in_signed = op_code == OP_DIV;
    assign mag_a     = in_signed && src_a[31] ? -src_a : src_a;
    assign mag_b     = in_signed && src_b[31] ? -src_b : src_b;
    assign div_start = op_valid && op_ready && !flush && (op_code == OP_DIV || op_code == OP_DIVU);
    assign q_neg     = op_q == OP_DIV && (a_q[31] ^ b_q[31]);
    assign r_neg     = op_q == OP_DIV && a_q[31];

    hilo_muldiv_div_iter #(.DIV_ITERS(DIV_ITERS)) u_div_iter (
        .clk      (clk),
        .rst      (rst),
        .start    (div_start),
        .en       (state_q == S_DIV),
        .dividend (mag_a),
        .divisor  (mag_b),
        .quot     (quot),
        .rem      (rem),
        .done     (div_done)
    );

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        ena_d   = 2'b00;
        hi_d    = hi_q;
        lo_d    = lo_q;
        if (flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: if (op_valid) begin
                    op_d = op_code;
                    a_d  = src_a;
                    b_d  = src_b;
                    if (op_code == OP_MTHI) begin
                        ena_d[HILO_HI_BIT] = 1'b1;
                        hi_d = src_a;
                    end else if (op_code == OP_MTLO) begin
                        ena_d[HILO_LO_BIT] = 1'b1;
                        lo_d = src_a;
                    end else if (op_code == OP_MULT || op_code == OP_MULTU) begin
                        state_d = S_MUL;
                    end else if (op_code == OP_DIV || op_code == OP_DIVU) begin
                        state_d = S_DIV;
                    end
                end
                S_MUL: begin
                    state_d = S_IDLE;
                    ena_d   = 2'b11;
                    hi_d    = prod[63:32];
                    lo_d    = prod[31:0];
                end
                S_DIV: state_d = div_done ? S_FIX : S_DIV;
                S_FIX: begin
                    state_d = S_IDLE;
                    ena_d   = 2'b11;
                    hi_d    = b_q == '0 ? a_q : r_neg ? -rem : rem;
                    lo_d    = b_q == '0 ? '1 : q_neg ? -quot : quot;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            ena_q   <= 2'b00;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            ena_q   <= ena_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end
endmodule

// File: tb/tb_hilo_muldiv.sv
// tb_hilo_muldiv: directed vectors with literal expectations, plus a schedule-based
// arithmetic model compared against the DUT on every falling edge.
module tb_hilo_muldiv;
    localparam logic [2:0] MULT = 3'd0, MULTU = 3'd1, DIV = 3'd2, DIVU = 3'd3, MTHI = 3'd4, MTLO = 3'd5;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        op_valid = 1'b0;
    logic [2:0]  op_code = '0;
    logic [31:0] src_a = '0;
    logic [31:0] src_b = '0;
    logic        flush = 1'b0;
    logic        op_ready;
    logic [1:0]  w_hilo_ena;
    logic [31:0] w_hi_data, w_lo_data;

    int n_chk = 0;
    int n_fail = 0;

    hilo_muldiv dut (
        .clk        (clk),
        .rst        (rst),
        .op_valid   (op_valid),
        .op_code    (op_code),
        .src_a      (src_a),
        .src_b      (src_b),
        .flush      (flush),
        .op_ready   (op_ready),
        .w_hilo_ena (w_hilo_ena),
        .w_hi_data  (w_hi_data),
        .w_lo_data  (w_lo_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Result of a MUL/DIV op as {ena, hi, lo}, straight from the arithmetic definition.
    function automatic logic [65:0] model(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (c == MULT) p = sa * sb;
        else if (c == MULTU) p = {32'd0, a} * {32'd0, b};
        else if (b == 32'd0) p = {a, 32'hFFFF_FFFF};
        else if (c == DIV) p = {32'(sa % sb), 32'(sa / sb)};
        else p = {a % b, a / b};
        return {2'b11, p};
    endfunction

    // Model: at most one result pending, due a fixed number of edges after accept.
    logic        pend = 1'b0, was_idle, m_rdy = 1'b1;
    int          pend_at = 0, cyc = 0;
    logic [65:0] pend_res = '0;
    logic [1:0]  m_ena = '0;
    logic [31:0] m_hi = '0, m_lo = '0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend = 1'b0; m_ena = '0; m_hi = '0; m_lo = '0; m_rdy = 1'b1;
        end else begin
            cyc++;
            was_idle = !pend;
            m_ena = '0;
            if (pend && (flush || pend_at == cyc)) begin
                if (!flush) begin
                    m_ena = pend_res[65:64]; m_hi = pend_res[63:32]; m_lo = pend_res[31:0];
                end
                pend = 1'b0;
            end
            if (was_idle && op_valid && !flush) begin
                if (op_code == MTHI) begin m_ena = 2'b10; m_hi = src_a; end
                else if (op_code == MTLO) begin m_ena = 2'b01; m_lo = src_a; end
                else if (op_code <= DIVU) begin
                    pend = 1'b1;
                    pend_at = cyc + (op_code <= MULTU ? 1 : 33);
                    pend_res = model(op_code, src_a, src_b);
                end
            end
            m_rdy = !pend;
        end
    end

    always @(negedge clk) begin
        chk("cmp_ena", w_hilo_ena, m_ena);
        chk("cmp_hi", w_hi_data, m_hi);
        chk("cmp_lo", w_lo_data, m_lo);
        chk("cmp_rdy", op_ready, m_rdy);
    end

    // Issue one op (called on a falling edge) and pin latency and result to literals.
    task automatic do_op(input string nm, input logic [2:0] c, input logic [31:0] a, input logic [31:0] b,
                         input int lat, input logic [1:0] e, input logic [31:0] h, input logic [31:0] l);
        int n;
        op_valid = 1'b1; op_code = c; src_a = a; src_b = b;
        @(negedge clk);
        op_valid = 1'b0; src_a = '1; src_b = '1;
        n = 1;
        while (w_hilo_ena == 2'b00 && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_lat"}, n, lat);
        chk({nm, "_ena"}, w_hilo_ena, e);
        chk({nm, "_hi"}, w_hi_data, h);
        chk({nm, "_lo"}, w_lo_data, l);
        chk({nm, "_rdy"}, op_ready, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int pulses;
        repeat (3) @(negedge clk);
        chk("rst_ena", w_hilo_ena, 2'b00);
        chk("rst_hi", w_hi_data, 32'h0);
        chk("rst_lo", w_lo_data, 32'h0);
        chk("rst_rdy", op_ready, 1'b1);
        #2 rst = 1'b1;
        @(negedge clk);

        do_op("mult_neg", MULT, 32'hFFFF_FFFF, 32'd2, 2, 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        do_op("multu", MULTU, 32'hFFFF_FFFF, 32'd2, 2, 2'b11, 32'h0000_0001, 32'hFFFF_FFFE);
        do_op("mult_big", MULT, 32'h7FFF_FFFF, 32'h8000_0000, 2, 2'b11, 32'hC000_0000, 32'h8000_0000);
        do_op("multu_big", MULTU, 32'h7FFF_FFFF, 32'h8000_0000, 2, 2'b11, 32'h3FFF_FFFF, 32'h8000_0000);
        do_op("div_neg", DIV, 32'hFFFF_FFF9, 32'd2, 34, 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        do_op("divu", DIVU, 32'd7, 32'd2, 34, 2'b11, 32'd1, 32'd3);
        do_op("div_negb", DIV, 32'd7, 32'hFFFF_FFFE, 34, 2'b11, 32'd1, 32'hFFFF_FFFD);
        do_op("div_zero", DIV, 32'd5, 32'd0, 34, 2'b11, 32'd5, 32'hFFFF_FFFF);
        do_op("divu_zero", DIVU, 32'd9, 32'd0, 34, 2'b11, 32'd9, 32'hFFFF_FFFF);
        do_op("div_ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 34, 2'b11, 32'h0, 32'h8000_0000);
        do_op("divu_big", DIVU, 32'hFFFF_FFFF, 32'h10, 34, 2'b11, 32'hF, 32'h0FFF_FFFF);

        op_valid = 1'b1; op_code = MTHI; src_a = 32'h1234_5678;
        @(negedge clk);
        op_code = MTLO; src_a = 32'hCAFE_BABE;
        chk("mthi_ena", w_hilo_ena, 2'b10);
        chk("mthi_hi", w_hi_data, 32'h1234_5678);
        @(negedge clk);
        op_valid = 1'b0;
        chk("mtlo_ena", w_hilo_ena, 2'b01);
        chk("mtlo_lo", w_lo_data, 32'hCAFE_BABE);

        op_valid = 1'b1; op_code = DIV; src_a = 32'd100; src_b = 32'd3;
        @(negedge clk);
        op_valid = 1'b0;
        repeat (9) @(negedge clk);
        flush = 1'b1; op_valid = 1'b1; op_code = MTHI; src_a = 32'hDEAD_BEEF;
        @(negedge clk);
        flush = 1'b0; op_valid = 1'b0;
        chk("flush_rdy", op_ready, 1'b1);
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            pulses += int'(w_hilo_ena != 2'b00);
            @(negedge clk);
        end
        chk("flush_pulses", pulses, 0);
        chk("flush_hi", w_hi_data, 32'h1234_5678);
        chk("flush_lo", w_lo_data, 32'hCAFE_BABE);

        op_valid = 1'b1; op_code = DIV; src_a = 32'd100; src_b = 32'd3;
        @(negedge clk);
        op_valid = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("arst_ena", w_hilo_ena, 2'b00);
        chk("arst_hi", w_hi_data, 32'h0);
        chk("arst_lo", w_lo_data, 32'h0);
        chk("arst_rdy", op_ready, 1'b1);
        @(negedge clk);
        #2 rst = 1'b1;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            pulses += int'(w_hilo_ena != 2'b00);
        end
        chk("arst_pulses", pulses, 0);
        chk("arst_rdy2", op_ready, 1'b1);

        do_op("post_rst", MULTU, 32'd3, 32'd5, 2, 2'b11, 32'd0, 32'd15);

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
